// File: rtl/oup_ulpi_regaccess.sv
// ULPI PHY register access sequencer: one REGW/REGR per request (immediate addressing),
// with PHY-abort retry, bus turnaround handling and a per-state wait timeout.
module oup_ulpi_regaccess #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_RETRIES    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [5:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] rdata_o,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_data_oe_o,
  output logic       ulpi_stp_o
);

  localparam logic [5:0]      EXTENDED_REG = 6'h2F;
  localparam int unsigned     TMR_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned     RTY_W        = $clog2(MAX_RETRIES + 2);
  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX     = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_TXCMD, S_WDATA, S_STP, S_RTURN, S_RDATA, S_WAIT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             write_q, write_d;
  logic [5:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       data_q, data_d;
  logic             oe_q, oe_d;
  logic             stp_q, stp_d;

  logic fail;
  logic abort;
  logic waiting;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fail    = 1'b0;
    abort   = 1'b0;
    waiting = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          write_d = req_write_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          retry_d = '0;
          if (req_addr_i == EXTENDED_REG) begin
            state_d = S_DONE;
            fail    = 1'b1;
          end else if (ulpi_dir_i) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_TXCMD;
          end
        end
      end
      S_TXCMD: begin
        if (ulpi_dir_i)      abort   = 1'b1;
        else if (ulpi_nxt_i) state_d = write_q ? S_WDATA : S_RTURN;
        else                 waiting = 1'b1;
      end
      S_WDATA: begin
        if (ulpi_dir_i)      abort   = 1'b1;
        else if (ulpi_nxt_i) state_d = S_STP;
        else                 waiting = 1'b1;
      end
      S_STP:   state_d = S_DONE;
      S_RTURN: begin
        if (ulpi_dir_i && !ulpi_nxt_i) state_d = S_RDATA;
        else if (ulpi_dir_i)           abort   = 1'b1;
        else                           waiting = 1'b1;
      end
      S_RDATA: begin
        if (ulpi_dir_i && !ulpi_nxt_i) begin
          rdata_d = ulpi_data_i;
          state_d = S_DONE;
        end else if (ulpi_nxt_i) begin
          abort = 1'b1;
        end else begin
          state_d = S_DONE;
          fail    = 1'b1;
        end
      end
      S_WAIT:  if (!ulpi_dir_i) state_d = S_TXCMD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      if (retry_q == RTY_MAX) begin
        state_d = S_DONE;
        fail    = 1'b1;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = S_WAIT;
      end
    end

    if (waiting) begin
      if (timer_q == TMR_LAST) begin
        state_d = S_DONE;
        fail    = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    // Any state change restarts the wait budget for the new state.
    if (state_d != state_q) timer_d = '0;

    // Outputs are a function of the next state so they register in step with it.
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
    err_d   = fail;
    oe_d    = (state_d inside {S_TXCMD, S_WDATA, S_STP});
    stp_d   = (state_d == S_STP);
    case (state_d)
      S_TXCMD: data_d = {(write_d ? 2'b10 : 2'b11), addr_d};
      S_WDATA: data_d = wdata_d;
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      retry_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      oe_q    <= 1'b0;
      stp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      data_q  <= data_d;
      oe_q    <= oe_d;
      stp_q   <= stp_d;
    end
  end

  assign req_ready_o    = ready_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign rdata_o        = rdata_q;
  assign ulpi_data_o    = data_q;
  assign ulpi_data_oe_o = oe_q;
  assign ulpi_stp_o     = stp_q;

endmodule

// File: tb/tb_oup_ulpi_regaccess.sv
// Bench for oup_ulpi_regaccess: directed protocol scenarios plus randomized register
// transactions, each cycle's pins compared against the expected ULPI sequence.
module tb_oup_ulpi_regaccess;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_write;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       done, err;
  logic [7:0] rdata;
  logic       dir, nxt;
  logic [7:0] din, dout;
  logic       oe, stp;

  int total = 0;
  int bad   = 0;
  logic [7:0] rexp;

  oup_ulpi_regaccess #(.TIMEOUT_CYCLES(64), .MAX_RETRIES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .done_o(done), .err_o(err), .rdata_o(rdata),
    .ulpi_dir_i(dir), .ulpi_nxt_i(nxt), .ulpi_data_i(din),
    .ulpi_data_o(dout), .ulpi_data_oe_o(oe), .ulpi_stp_o(stp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic w, input logic [5:0] a, input logic [7:0] wd);
    chk("acc_ready", 32'(req_ready), 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
    step();
    // Scramble request fields afterwards: the DUT must use latched copies.
    req_valid = 1'b0; req_write = ~w; req_addr = 6'($urandom); req_wdata = 8'($urandom);
  endtask

  // Write: optional abort after `pre` TXCMD cycles with DIR held `hold` cycles,
  // then NXT after d1 TXCMD wait cycles and d2 WDATA wait cycles.
  task automatic do_write(input logic [5:0] a, input logic [7:0] wd, input int unsigned pre,
                          input int unsigned hold, input int unsigned d1, input int unsigned d2);
    logic [7:0] cmd;
    cmd = {2'b10, a};
    accept(1'b1, a, wd);
    if (hold != 0) begin
      for (int unsigned i = 0; i < pre; i++) begin
        chk("wr_pre_oe", 32'(oe), 1); chk("wr_pre_cmd", 32'(dout), 32'(cmd)); step();
      end
      dir = 1'b1;
      for (int unsigned i = 0; i < hold; i++) begin
        chk("wr_abort_oe", 32'(oe), 32'(i == 0)); step();
      end
      dir = 1'b0;
      chk("wr_turn_oe", 32'(oe), 0); chk("wr_turn_done", 32'(done), 0); step();
    end
    for (int unsigned i = 0; i <= d1; i++) begin
      chk("wr_cmd_oe", 32'(oe), 1); chk("wr_cmd", 32'(dout), 32'(cmd)); chk("wr_cmd_stp", 32'(stp), 0);
      nxt = (i == d1); step();
    end
    for (int unsigned i = 0; i <= d2; i++) begin
      chk("wr_data_oe", 32'(oe), 1); chk("wr_data", 32'(dout), 32'(wd)); chk("wr_data_stp", 32'(stp), 0);
      nxt = (i == d2); step();
    end
    nxt = 1'b0;
    chk("wr_stp", 32'(stp), 1); chk("wr_stp_oe", 32'(oe), 1); chk("wr_stp_data", 32'(dout), 0);
    chk("wr_stp_done", 32'(done), 0);
    step();
    chk("wr_done", 32'(done), 1); chk("wr_err", 32'(err), 0); chk("wr_done_oe", 32'(oe), 0);
    chk("wr_done_stp", 32'(stp), 0); chk("wr_rdata_held", 32'(rdata), 32'(rexp));
    step();
    chk("wr_idle_ready", 32'(req_ready), 1); chk("wr_idle_done", 32'(done), 0);
  endtask

  // Read: NXT after d1 TXCMD wait cycles, t idle cycles in turnaround, then DIR
  // high (turnaround) and the register value one cycle later.
  task automatic do_read(input logic [5:0] a, input int unsigned d1, input int unsigned t,
                         input logic [7:0] rd);
    logic [7:0] cmd;
    cmd = {2'b11, a};
    accept(1'b0, a, 8'h00);
    for (int unsigned i = 0; i <= d1; i++) begin
      chk("rd_cmd_oe", 32'(oe), 1); chk("rd_cmd", 32'(dout), 32'(cmd));
      nxt = (i == d1); step();
    end
    nxt = 1'b0;
    for (int unsigned i = 0; i < t; i++) begin
      chk("rd_wait_oe", 32'(oe), 0); step();
    end
    dir = 1'b1;
    chk("rd_turn_oe", 32'(oe), 0); step();
    din = rd;
    chk("rd_data_oe", 32'(oe), 0); chk("rd_data_done", 32'(done), 0); step();
    dir = 1'b0; din = 8'($urandom);
    rexp = rd;
    chk("rd_done", 32'(done), 1); chk("rd_err", 32'(err), 0);
    chk("rd_rdata", 32'(rdata), 32'(rexp)); chk("rd_done_oe", 32'(oe), 0);
    step();
    chk("rd_idle_ready", 32'(req_ready), 1); chk("rd_idle_done", 32'(done), 0);
    chk("rd_rdata_hold", 32'(rdata), 32'(rexp));
  endtask

  initial begin
    int unsigned n;
    logic        fin;
    logic [5:0]  a;
    logic [7:0]  d;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    dir = 1'b0; nxt = 1'b0; din = '0; rexp = 8'h00;
    repeat (3) step();
    chk("rst_ready", 32'(req_ready), 1); chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0); chk("rst_rdata", 32'(rdata), 0);
    chk("rst_dout", 32'(dout), 0); chk("rst_oe", 32'(oe), 0); chk("rst_stp", 32'(stp), 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(req_ready), 1);

    do_write(6'h04, 8'h45, 0, 0, 2, 1);
    do_read(6'h00, 0, 0, 8'h24);
    do_write(6'h0A, 8'h5A, 1, 3, 0, 0);

    // PHY raises DIR on every TXCMD: four retries, fifth abort ends in error.
    accept(1'b1, 6'h16, 8'h3C);
    for (int k = 0; k < 5; k++) begin
      chk("rty_oe", 32'(oe), 1); chk("rty_cmd", 32'(dout), 32'h96); chk("rty_done", 32'(done), 0);
      dir = 1'b1; step(); dir = 1'b0;
      if (k < 4) begin
        chk("rty_turn_oe", 32'(oe), 0); step();
      end
    end
    chk("rty_exh_done", 32'(done), 1); chk("rty_exh_err", 32'(err), 1); chk("rty_exh_oe", 32'(oe), 0);
    step();
    chk("rty_exh_ready", 32'(req_ready), 1);
    do_write(6'h16, 8'hC3, 0, 2, 1, 0);

    // NXT never comes: TX CMD held for the whole wait budget, then error.
    accept(1'b0, 6'h11, 8'h00);
    n = 0; fin = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      if (done) fin = 1'b1;
      else begin
        if (oe) n++;
        step();
      end
    end
    chk("to_seen", 32'(fin), 1); chk("to_oe_cycles", n, 64);
    chk("to_err", 32'(err), 1); chk("to_oe", 32'(oe), 0); chk("to_rdata", 32'(rdata), 32'(rexp));
    step();
    chk("to_ready", 32'(req_ready), 1);

    accept(1'b1, 6'h2F, 8'hFF);
    chk("ext_done", 32'(done), 1); chk("ext_err", 32'(err), 1); chk("ext_oe", 32'(oe), 0);
    step();
    chk("ext_ready", 32'(req_ready), 1); chk("ext_oe2", 32'(oe), 0); chk("ext_done2", 32'(done), 0);

    // Reset pulse while the write data is on the bus.
    accept(1'b1, 6'h05, 8'h77);
    chk("mr_cmd_oe", 32'(oe), 1); nxt = 1'b1; step(); nxt = 1'b0;
    chk("mr_wdata", 32'(dout), 32'h77);
    #2 rst_n = 1'b0;
    #1;
    rexp = 8'h00;
    chk("mr_oe", 32'(oe), 0); chk("mr_stp", 32'(stp), 0); chk("mr_done", 32'(done), 0);
    step(); step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("mr_post_done", 32'(done), 0); chk("mr_post_ready", 32'(req_ready), 1);
      chk("mr_post_oe", 32'(oe), 0);
    end
    chk("mr_rdata", 32'(rdata), 32'(rexp));

    for (int it = 0; it < 16; it++) begin
      a = 6'($urandom_range(0, 62));
      if (a == 6'h2F) a = 6'h2E;
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 2) == 0)
          do_write(a, d, $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 5), $urandom_range(0, 5));
        else
          do_write(a, d, 0, 0, $urandom_range(0, 5), $urandom_range(0, 5));
      end else begin
        do_read(a, $urandom_range(0, 5), $urandom_range(0, 4), d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
